// File: rtl/x_mem_pkg.sv
// Shared types and default widths for the memory arbiter and the core memory interface.
package x_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_sm_t;

  localparam int X_AW = 32;
  localparam int X_DW = 32;

endpackage

// File: rtl/x_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1, wrapping.
module x_rr_pick
  import x_mem_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int LW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [LW-1:0]    i_last,
  output logic             o_any,
  output logic [LW-1:0]    o_idx
);

  logic          w_found_hi;
  logic [LW-1:0] w_idx_hi;
  logic          w_found_lo;
  logic [LW-1:0] w_idx_lo;

  // Indices above last win over the wrapped-around ones at or below last.
  always_comb begin
    w_found_hi = 1'b0;
    w_idx_hi   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found_hi && i_req[i] && (LW'(i) > i_last)) begin
        w_found_hi = 1'b1;
        w_idx_hi   = LW'(i);
      end
    end
  end

  always_comb begin
    w_found_lo = 1'b0;
    w_idx_lo   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found_lo && i_req[i] && (LW'(i) <= i_last)) begin
        w_found_lo = 1'b1;
        w_idx_lo   = LW'(i);
      end
    end
  end

  assign o_any = w_found_hi | w_found_lo;
  assign o_idx = w_found_hi ? w_idx_hi : w_idx_lo;

endmodule

// File: rtl/x_mem_arb.sv
// Round-robin arbiter sharing one valid/accept memory port between N_REQ requesters.
module x_mem_arb
  import x_mem_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = X_AW,
  parameter int DW    = X_DW,
  localparam int GW   = $clog2(N_REQ)
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  logic [N_REQ-1:0]    i_req_valid,
  input  logic [N_REQ-1:0]    i_req_rnw,
  input  logic [N_REQ*AW-1:0] i_req_addr,
  input  logic [N_REQ*DW-1:0] i_req_data,
  output logic [N_REQ-1:0]    o_req_accept,
  output logic [DW-1:0]       o_req_data,
  output logic                o_valid,
  output logic                o_rnw,
  output logic [AW-1:0]       o_addr,
  output logic [DW-1:0]       o_data,
  input  logic                i_accept,
  input  logic [DW-1:0]       i_data,
  output logic                o_busy,
  output logic [GW-1:0]       o_grant
);

  generate
    if (N_REQ < 2) begin : g_bad_nreq
      $error("x_mem_arb needs at least two requesters");
    end
  endgenerate

  arb_sm_t       r_sm;
  arb_sm_t       w_sm_nxt;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] w_grant_nxt;
  logic [GW-1:0] r_last;
  logic [GW-1:0] w_last_nxt;

  logic          w_any;
  logic [GW-1:0] w_pick;
  logic          w_sel_valid;
  logic          w_sel_rnw;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_data;

  x_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req  (i_req_valid),
    .i_last (r_last),
    .o_any  (w_any),
    .o_idx  (w_pick)
  );

  assign w_sel_valid = i_req_valid[r_grant];
  assign w_sel_rnw   = i_req_rnw[r_grant];
  assign w_sel_addr  = i_req_addr[r_grant*AW +: AW];
  assign w_sel_data  = i_req_data[r_grant*DW +: DW];

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_sm    <= IDLE;
      r_grant <= '0;
      r_last  <= GW'(N_REQ - 1);
    end else begin
      r_sm    <= w_sm_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Memory-side fields are driven only while a grant is held so IDLE and reset present all zeros.
  always_comb begin
    w_sm_nxt     = r_sm;
    w_grant_nxt  = r_grant;
    w_last_nxt   = r_last;
    o_valid      = 1'b0;
    o_rnw        = 1'b0;
    o_addr       = '0;
    o_data       = '0;
    o_req_accept = '0;
    unique case (r_sm)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_sm_nxt    = BUSY;
        end
      end
      BUSY: begin
        o_valid = w_sel_valid;
        o_rnw   = w_sel_rnw;
        o_addr  = w_sel_addr;
        o_data  = w_sel_data;
        if (!w_sel_valid) begin
          // Requester withdrew: release the port without an accept.
          w_last_nxt = r_grant;
          w_sm_nxt   = IDLE;
        end else if (i_accept) begin
          for (int i = 0; i < N_REQ; i++) begin
            o_req_accept[i] = (GW'(i) == r_grant);
          end
          w_last_nxt = r_grant;
          w_sm_nxt   = IDLE;
        end
      end
      default: begin
        w_sm_nxt = IDLE;
      end
    endcase
  end

  assign o_req_data = i_data;
  assign o_busy     = (r_sm == BUSY);
  assign o_grant    = r_grant;

endmodule

// File: tb/tb_x_mem_arb.sv
// Table-driven bench for x_mem_arb with a scoreboard on requester accepts and read data.
module tb_x_mem_arb;

  localparam int N_REQ = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic               clk;
  logic               nrst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_rnw;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]   req_accept;
  logic [DW-1:0]      req_rdata;
  logic               m_valid;
  logic               m_rnw;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_data;
  logic               m_accept;
  logic [DW-1:0]      m_rdata;
  logic               busy;
  logic               grant;

  x_mem_arb #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_req_valid  (req_valid),
    .i_req_rnw    (req_rnw),
    .i_req_addr   (req_addr),
    .i_req_data   (req_data),
    .o_req_accept (req_accept),
    .o_req_data   (req_rdata),
    .o_valid      (m_valid),
    .o_rnw        (m_rnw),
    .o_addr       (m_addr),
    .o_data       (m_data),
    .i_accept     (m_accept),
    .i_data       (m_rdata),
    .o_busy       (busy),
    .o_grant      (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        nrst;
    logic [1:0]  v;
    logic        acc;
    logic [31:0] idata;
    logic [1:0]  eracc;
    logic        eov;
    logic        ebusy;
    logic        egrant;
  } vec_t;

  typedef struct {
    logic [1:0]  acc;
    logic [31:0] data;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic [1:0] v, input logic acc, input logic [31:0] idata,
                     input logic [1:0] eracc, input logic eov, input logic ebusy, input logic egrant);
    vec_t t;
    t.nrst = r; t.v = v; t.acc = acc; t.idata = idata;
    t.eracc = eracc; t.eov = eov; t.ebusy = ebusy; t.egrant = egrant;
    tbl.push_back(t);
  endtask

  // req0 is a reader at 0x100, req1 a writer of 0x1234 to 0x200.
  function automatic logic [69:0] expv(input vec_t t);
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    r = 1'b0; a = '0; d = '0;
    if (t.ebusy) begin
      r = !t.egrant;
      a = t.egrant ? 32'h200 : 32'h100;
      d = t.egrant ? 32'h1234 : 32'h5555;
    end
    return {t.eracc, t.eov, r, a, d, t.ebusy, t.egrant};
  endfunction

  function automatic logic [69:0] actv();
    return {req_accept, m_valid, m_rnw, m_addr, m_data, busy, grant};
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (acc,valid,rnw,addr,data,busy,grant)", name, act, exp);
    end
  endtask

  // Scoreboard: every accept the DUT gives must match the next expected one.
  always @(negedge clk) begin
    if (req_accept !== 2'b00) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: accept %b data %h, none expected", req_accept, req_rdata);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        if (req_accept !== e.acc || req_rdata !== e.data) begin
          n_err++;
          $display("FAIL sb_accept: got acc %b data %h want acc %b data %h",
                   req_accept, req_rdata, e.acc, e.data);
        end
      end
    end
  end

  initial begin
    nrst      = 1'b0;
    req_valid = '0;
    req_rnw   = 2'b01;
    req_addr  = {32'h200, 32'h100};
    req_data  = {32'h1234, 32'h5555};
    m_accept  = 1'b0;
    m_rdata   = '0;

    add(0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    // single read, accept two cycles after valid
    add(1, 2'b01, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b01, 0, 0, 2'b00, 1, 1, 0);
    add(1, 2'b01, 0, 0, 2'b00, 1, 1, 0);
    add(1, 2'b01, 1, 32'hDEADBEEF, 2'b01, 1, 1, 0);
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    // contention straight after reset alternates 0,1,0,1
    add(0, 2'b11, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b11, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b11, 1, 32'hA0, 2'b01, 1, 1, 0);
    add(1, 2'b11, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b11, 1, 32'hA1, 2'b10, 1, 1, 1);
    add(1, 2'b11, 0, 0, 2'b00, 0, 0, 1);
    add(1, 2'b11, 1, 32'hA2, 2'b01, 1, 1, 0);
    add(1, 2'b11, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b11, 1, 32'hA3, 2'b10, 1, 1, 1);
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 1);
    // write with accept tied high; accept in IDLE is ignored
    add(1, 2'b10, 1, 32'hB0, 2'b00, 0, 0, 1);
    add(1, 2'b10, 1, 32'hB1, 2'b10, 1, 1, 1);
    add(1, 2'b00, 1, 0, 2'b00, 0, 0, 1);
    // stall req0 for 10 cycles with req1 waiting
    add(1, 2'b11, 0, 0, 2'b00, 0, 0, 1);
    for (int i = 0; i < 10; i++) add(1, 2'b11, 0, 0, 2'b00, 1, 1, 0);
    add(1, 2'b11, 1, 32'hC0, 2'b01, 1, 1, 0);
    add(1, 2'b11, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b11, 1, 32'hC1, 2'b10, 1, 1, 1);
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 1);
    // abort by req1 (accept during the abort must not leak), then last=1 favours req0
    add(1, 2'b01, 0, 0, 2'b00, 0, 0, 1);
    add(1, 2'b01, 1, 32'hD0, 2'b01, 1, 1, 0);
    add(1, 2'b10, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b10, 0, 0, 2'b00, 1, 1, 1);
    add(1, 2'b00, 1, 32'hDD, 2'b00, 0, 1, 1);
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 1);
    add(1, 2'b11, 0, 0, 2'b00, 0, 0, 1);
    add(1, 2'b11, 1, 32'hD1, 2'b01, 1, 1, 0);
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 0);
    // reset during a stalled transaction restores req0 priority
    add(1, 2'b01, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b01, 0, 0, 2'b00, 1, 1, 0);
    add(0, 2'b01, 0, 0, 2'b00, 0, 0, 0);
    add(0, 2'b11, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b11, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b11, 1, 32'hE0, 2'b01, 1, 1, 0);
    add(1, 2'b00, 0, 0, 2'b00, 0, 0, 0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      nrst      = tbl[i].nrst;
      req_valid = tbl[i].v;
      m_accept  = tbl[i].acc;
      m_rdata   = tbl[i].idata;
      if (tbl[i].eracc != 2'b00) begin
        sb_t e;
        e.acc  = tbl[i].eracc;
        e.data = tbl[i].idata;
        sbq.push_back(e);
      end
      #2;
      chk($sformatf("row%0d", i), actv(), expv(tbl[i]));
    end

    // asynchronous reset asserted mid-cycle must clear outputs without a clock edge
    @(posedge clk);
    #1;
    nrst = 1'b1; req_valid = 2'b01; m_accept = 1'b0; m_rdata = 32'hFFFF0000;
    @(posedge clk);
    #1;
    chk("pre_async_rst", actv(), {2'b00, 1'b1, 1'b1, 32'h100, 32'h5555, 1'b1, 1'b0});
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst", actv(), 70'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1; req_valid = 2'b00;
    repeat (2) @(posedge clk);

    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d accepts outstanding, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
